// File: rtl/lab3_mem_line_word_bridge_if.sv
// Message types and handshake bundle for the line-to-word memory bridge.
// Line side is 16B cache traffic, word side is 4B test-memory traffic.
package lab3_mem_pkg;

    localparam logic [3:0] MEM_READ  = 4'd0;
    localparam logic [3:0] MEM_WRITE = 4'd1;

    typedef struct packed {
        logic [3:0]   type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [3:0]   type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    typedef struct packed {
        logic [3:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [3:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

interface lab3_mem_line_word_bridge_if;
    import lab3_mem_pkg::*;

    mem_req_16B_t  linereq_msg;
    logic          linereq_val;
    logic          linereq_rdy;
    mem_resp_16B_t lineresp_msg;
    logic          lineresp_val;
    logic          lineresp_rdy;
    mem_req_4B_t   wordreq_msg;
    logic          wordreq_val;
    logic          wordreq_rdy;
    mem_resp_4B_t  wordresp_msg;
    logic          wordresp_val;
    logic          wordresp_rdy;

    modport slave (
        input  linereq_msg, linereq_val,
        output linereq_rdy,
        output lineresp_msg, lineresp_val,
        input  lineresp_rdy,
        output wordreq_msg, wordreq_val,
        input  wordreq_rdy,
        input  wordresp_msg, wordresp_val,
        output wordresp_rdy
    );

    modport master (
        output linereq_msg, linereq_val,
        input  linereq_rdy,
        input  lineresp_msg, lineresp_val,
        output lineresp_rdy,
        input  wordreq_msg, wordreq_val,
        output wordreq_rdy,
        output wordresp_msg, wordresp_val,
        input  wordresp_rdy
    );

endinterface

// File: rtl/lab3_mem_line_word_bridge.sv
// Splits 16B line requests into four serial 4B word transactions and
// reassembles the word responses into a single line response.
module lab3_mem_line_word_bridge
    import lab3_mem_pkg::*;
#(
    parameter int p_num_beats = 4
) (
    input  logic clk,
    input  logic reset,
    lab3_mem_line_word_bridge_if.slave bus,
    output logic err
);

    if (p_num_beats != 4) begin : g_bad_beats
        $error("lab3_mem_line_word_bridge: p_num_beats must be 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [1:0]   beat_q;
    logic [1:0]   beat_d;
    logic [3:0]   type_q;
    logic [7:0]   opaque_q;
    logic [27:0]  line_q;
    logic [127:0] data_q;
    logic [127:0] asm_q;

    logic is_wr;
    logic linereq_go;
    logic wordreq_go;
    logic wordresp_go;
    logic lineresp_go;

    assign is_wr       = (type_q == MEM_WRITE);
    assign linereq_go  = bus.linereq_val && bus.linereq_rdy;
    assign wordreq_go  = bus.wordreq_val && bus.wordreq_rdy;
    assign wordresp_go = bus.wordresp_val && bus.wordresp_rdy;
    assign lineresp_go = bus.lineresp_val && bus.lineresp_rdy;

    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        bus.linereq_rdy  = 1'b0;
        bus.wordreq_val  = 1'b0;
        bus.wordresp_rdy = 1'b0;
        bus.lineresp_val = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.linereq_rdy = 1'b1;
                if (linereq_go) begin
                    state_d = REQ;
                    beat_d  = 2'd0;
                end
            end
            REQ: begin
                bus.wordreq_val = 1'b1;
                if (wordreq_go) state_d = WAIT;
            end
            WAIT: begin
                bus.wordresp_rdy = 1'b1;
                if (wordresp_go) begin
                    if (beat_q == 2'd3) begin
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                        beat_d  = beat_q + 2'd1;
                    end
                end
            end
            RESP: begin
                bus.lineresp_val = 1'b1;
                if (lineresp_go) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshakes stay quiet for the whole reset window.
        if (reset) begin
            bus.linereq_rdy  = 1'b0;
            bus.wordreq_val  = 1'b0;
            bus.wordresp_rdy = 1'b0;
            bus.lineresp_val = 1'b0;
        end
    end

    always_comb begin
        bus.wordreq_msg        = '0;
        bus.wordreq_msg.type_  = type_q;
        bus.wordreq_msg.opaque = {6'b0, beat_q};
        bus.wordreq_msg.addr   = {line_q, beat_q, 2'b00};
        bus.wordreq_msg.len    = 2'd0;
        bus.wordreq_msg.data   = is_wr ? data_q[32*beat_q +: 32] : 32'd0;

        bus.lineresp_msg        = '0;
        bus.lineresp_msg.type_  = type_q;
        bus.lineresp_msg.opaque = opaque_q;
        bus.lineresp_msg.test   = 2'd0;
        bus.lineresp_msg.len    = 4'd0;
        bus.lineresp_msg.data   = is_wr ? 128'd0 : asm_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            err      <= 1'b0;
            type_q   <= 4'd0;
            opaque_q <= 8'd0;
            line_q   <= 28'd0;
            data_q   <= 128'd0;
            asm_q    <= 128'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (linereq_go) begin
                type_q   <= bus.linereq_msg.type_;
                opaque_q <= bus.linereq_msg.opaque;
                line_q   <= bus.linereq_msg.addr[31:4];
                data_q   <= bus.linereq_msg.data;
                asm_q    <= 128'd0;
            end
            if (wordresp_go) begin
                // A stray opaque is flagged but the line still completes.
                if (bus.wordresp_msg.opaque != {6'b0, beat_q}) err <= 1'b1;
                if (!is_wr) asm_q[32*beat_q +: 32] <= bus.wordresp_msg.data;
            end
        end
    end

endmodule
